// File: rtl/serial_sub_if.sv
// Operand/result handshake bundle for serial_sub: valid/ready on both the operand and result sides.
// The master drives operands and result acceptance; the slave is the subtractor.
interface serial_sub_if #(
    parameter int WIDTH = 4
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] num1;
    logic [WIDTH-1:0] num2;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;

    modport master (
        output in_valid, num1, num2, out_ready,
        input  in_ready, out_valid, diff, bout
    );

    modport slave (
        input  in_valid, num1, num2, out_ready,
        output in_ready, out_valid, diff, bout
    );
endinterface

// File: rtl/serial_sub.sv
// Bit-serial unsigned subtractor, LSB first, one bit per cycle; result valid WIDTH edges after accept.
// Accepts one operand pair only in IDLE and holds diff/bout in DONE until out_ready (unbounded stall).
module serial_sub #(
    parameter int WIDTH = 4
) (
    input logic         clk,
    input logic         rst,
    serial_sub_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] diff_reg;
    logic             br;
    logic             bout_reg;
    logic [CW-1:0]    cnt;

    logic             abit;
    logic             bbit;
    logic             dbit;
    logic             br_nxt;
    logic             last_bit;
    logic             in_ready_c;
    logic             out_valid_c;

    // Full subtractor on the bit selected by the counter.
    always_comb begin
        abit     = a_reg[cnt];
        bbit     = b_reg[cnt];
        dbit     = abit ^ bbit ^ br;
        br_nxt   = (~abit & bbit) | (~(abit ^ bbit) & br);
        last_bit = (cnt == LAST);
    end

    always_comb begin
        state_nxt   = state;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        case (state)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg    <= '0;
            b_reg    <= '0;
            diff_reg <= '0;
            br       <= 1'b0;
            bout_reg <= 1'b0;
            cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_reg <= bus.num1;
                        b_reg <= bus.num2;
                        br    <= 1'b0;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    diff_reg[cnt] <= dbit;
                    br            <= br_nxt;
                    cnt           <= cnt + 1'b1;
                    if (last_bit) begin
                        bout_reg <= br_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.diff      = diff_reg;
    assign bus.bout      = bout_reg;
endmodule

// File: doc/serial_sub.md
SERIAL_SUB -- requirements
Module: serial_sub

Interface
REQ-001 Parameter: WIDTH, default 4, operand/result width in bits; WIDTH >= 2 SHALL be supported.
REQ-002 clk  input  1  single clock; all state SHALL update on rising edge only.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 in_valid  input  1  operands present on num1/num2.
REQ-005 in_ready  output  1  block can accept a new operand pair.
REQ-006 num1  input  WIDTH  minuend, unsigned.
REQ-007 num2  input  WIDTH  subtrahend, unsigned.
REQ-008 out_valid  output  1  diff/bout hold a completed result.
REQ-009 out_ready  input  1  consumer accepts result.
REQ-010 diff  output  WIDTH  num1 - num2 modulo 2^WIDTH.
REQ-011 bout  output  1  final borrow; 1 when num1 < num2.

Function
REQ-012 FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-013 in_ready SHALL be 1 in IDLE only; 0 in RUN and DONE.
REQ-014 out_valid SHALL be 1 in DONE only.
REQ-015 IDLE: in_valid=1 at an edge SHALL capture num1, num2, clear borrow and bit counter, enter RUN; in_valid=0 SHALL stay in IDLE.
REQ-016 RUN: one bit per cycle, LSB first, via full-subtractor: d = a ^ b ^ br; br' = (~a & b) | (~(a ^ b) & br), bit i stored into diff register bit i.
REQ-017 RUN SHALL last exactly WIDTH cycles; on the edge processing bit WIDTH-1, FSM SHALL enter DONE and bout SHALL take final br'.
REQ-018 Latency: out_valid SHALL assert WIDTH clock edges after the accepting edge (WIDTH=4: accept at edge N, out_valid=1 after edge N+4).
REQ-019 DONE: diff and bout SHALL hold stable while out_ready=0 (unbounded backpressure).
REQ-020 DONE with out_ready=1 at an edge SHALL return to IDLE; no new operand accepted on that same edge (in_ready was 0).
REQ-021 num1/num2/in_valid changes during RUN or DONE SHALL be ignored; captured operands alone determine result.
REQ-022 diff/bout SHALL only be guaranteed valid when out_valid=1; outside DONE they MAY show partial results.
REQ-023 Wrap-around: diff SHALL equal (num1 + 2^WIDTH - num2) mod 2^WIDTH in all cases; bout SHALL equal (num1 < num2).
REQ-024 Equal operands SHALL yield diff=0, bout=0.

Reset
REQ-025 rst=1 at an edge SHALL force IDLE, diff=0, bout=0, borrow=0, counter=0, out_valid=0; in_ready=1 from the following cycle.
REQ-026 rst SHALL dominate all other inputs, including in_valid and out_ready on the same edge.
REQ-027 rst during RUN or DONE SHALL discard the operation; no out_valid pulse SHALL follow.

Verification
REQ-028 WIDTH=4, num1=9, num2=3, out_ready=1 -> out_valid after 4 edges, diff=6, bout=0, back to IDLE next edge.
REQ-029 num1=3, num2=9 -> diff=0xA, bout=1; num1=0, num2=1 -> diff=0xF, bout=1.
REQ-030 num1=15, num2=15 -> diff=0, bout=0; num1=15, num2=0 -> diff=15, bout=0.
REQ-031 Backpressure: out_ready=0 for 10 cycles in DONE -> out_valid, diff, bout stable, in_ready=0 throughout; out_ready=1 -> IDLE next edge.
REQ-032 Operand change/in_valid pulses during RUN (num1=9,num2=3 accepted, then 0/15 driven) -> result still diff=6, bout=0, only one transaction.
REQ-033 rst asserted on 2nd RUN cycle -> next cycle IDLE, in_ready=1, out_valid=0, diff=0; fresh 5-2 afterwards -> diff=3, bout=0.
